gb_cu_sequencer: RTL
====================

# gb_cu_sequencer

Microcode sequencer for the CPU control unit. Holds the current opcode, CB-prefix mode and micro-step, and forms the microcode ROM address from them. It gates the ROM word onto the 70-bit `control_signals` bus that the control-word field splitter decodes into datapath selects. It advances, branches, stalls or ends the instruction according to the advance field in the word it is currently issuing.

## Interface

Parameters:
- `STEP_W`, default 3: micro-step counter width; 8 steps per opcode.
- `IDLE_WORD`, default 70'h0_0000_0008_0000_0020: control word issued while not running. Only `db_nread` (bit 35) and `db_nwrite` (bit 5) are high.

Ports:
- `clock`, input, 1: system clock.
- `reset`, input, 1: synchronous, active-high.
- `inst_byte`, input, 8: instruction buffer contents; the opcode for the next instruction.
- `cond_met`, input, 1: branch condition result from the flag logic.
- `mem_ready`, input, 1: data bus can complete this cycle's access.
- `wake`, input, 1: releases a HOLD step (interrupt or joypad wake).
- `ucode_addr`, output, 12: `{cb_mode, opcode[7:0], step[2:0]}`.
- `ucode_data`, input, 70: combinational microcode ROM word for `ucode_addr`.
- `control_signals`, output, 70: control word to the field splitter.
- `cb_mode`, output, 1: executing a CB-page opcode.
- `inst_done`, output, 1: one-cycle pulse on the cycle an instruction ends.
- `retired`, output, 16: count of instructions ended; wraps.
- `ucode_err`, output, 1: sticky; step counter overflow seen.

## Operation

- State: `BOOT` and `RUN`. Registers: `opcode`, `step`, `cb_mode`, `retired`, `ucode_err`.
- `BOOT` is entered on reset and lasts exactly one cycle:
  - `control_signals = IDLE_WORD`.
  - Next state is `RUN`, with `opcode=8'h00`, `step=0`, `cb_mode=0`.
- In `RUN`, `control_signals = ucode_data`. The advance field is `adv = ucode_data[34:33]`; toggle is `ucode_data[48]`.
- Stall: a memory access is pending when `ucode_data[35]==0 || ucode_data[5]==0`. If it is pending and `mem_ready==0`, all registers hold, the same address is re-issued, and `adv` is ignored.
- Advance decode, when not stalled:
  - `2'b00` NEXT: `step <= step+1`.
  - `2'b01` END: `opcode <= inst_byte`, `step <= 0`, `inst_done=1`, `retired <= retired+1`. `cb_mode <= ucode_data[48] ? ~cb_mode : 0`.
  - `2'b10` COND: if `cond_met`, behave as NEXT; otherwise behave as END.
  - `2'b11` HOLD: `step` holds; when `wake==1`, behave as NEXT.
- Overflow: NEXT (or a NEXT taken via COND or HOLD) at `step==7` behaves as END and sets `ucode_err`. `ucode_err` clears only on reset.
- Toggle bit is honoured only on END and COND-as-END. It is ignored on other steps.
- `inst_done` is combinational from the current word and `mem_ready`. It is never asserted in `BOOT`.
- `retired` wraps from 16'hFFFF to 0.

## Timing

- Reset (sampled at `clock` edge with `reset=1`):
  - State becomes `BOOT`.
  - `opcode=0`, `step=0`, `cb_mode=0`, `retired=0`, `ucode_err=0`.
  - `control_signals=IDLE_WORD`, `inst_done=0`, `ucode_addr=12'h000`.
- Reset asserted mid-instruction (including while stalled or in HOLD): the next edge abandons the instruction. No `inst_done` pulse and no count for it.
- Latency:
  - `ucode_addr` to `control_signals` is zero cycles; the path is combinational through the ROM.
  - State changes take effect on the edge ending the current step.
  - Each non-stalled step lasts exactly 1 cycle.
- Simultaneous cases:
  - Stall has priority over HOLD/wake and over END: a stalled END neither retires nor loads the opcode.
  - `wake` during a stall is ignored. `wake` is not latched.
- The first instruction fetched after reset is executed from opcode 8'h00, step 0. That microcode's END loads the real opcode.

## Test plan

- Reset then run: hold `reset` 2 cycles, release.
  - Cycle 1: `control_signals==IDLE_WORD`, `ucode_addr==0`.
  - Cycle 2: `control_signals==ucode_data` of address 0.
- Straight-line opcode: ROM for opcode 8'h3E gives steps 0,1 NEXT and step 2 END; `inst_byte=8'h00`.
  - Addresses must be 0x1F0, 0x1F1, 0x1F2.
  - Then 0x000, with one `inst_done` pulse and `retired` incrementing by 1.
- CB prefix: opcode 8'hCB step 0 = END with toggle.
  - Next address is `{1,inst_byte,0}`.
  - That CB opcode's END without toggle returns `cb_mode` to 0.
- Memory stall: step with `ucode_data[35]=0` and `mem_ready=0` for 3 cycles.
  - Address is held 4 cycles and `control_signals` is unchanged.
  - Advances the cycle `mem_ready=1`.
- COND and HOLD:
  - COND with `cond_met=0` at step 1 ends the instruction (`inst_done`); with `cond_met=1` it goes to step 2.
  - HOLD stays put for 5 cycles and advances the cycle after `wake=1`.
- Overflow and wrap:
  - Force NEXT at step 7: END occurs and `ucode_err=1`, remaining set until reset.
  - Preload `retired` to 16'hFFFF via 65535 instructions (or a backdoor), then one END: `retired==0`.

Source files
------------

// File: rtl/gb_cu_sequencer.sv
// Microcode sequencer: tracks opcode / CB page / micro-step, forms the ROM address
// and steps through the microcode according to each word's advance field.
module gb_cu_sequencer #(
  parameter int          STEP_W    = 3,
  parameter logic [69:0] IDLE_WORD = 70'h0_0000_0008_0000_0020
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        inst_byte,
  input  logic              cond_met,
  input  logic              mem_ready,
  input  logic              wake,
  output logic [8+STEP_W:0] ucode_addr,
  input  logic [69:0]       ucode_data,
  output logic [69:0]       control_signals,
  output logic              cb_mode,
  output logic              inst_done,
  output logic [15:0]       retired,
  output logic              ucode_err
);

  typedef enum logic {ST_BOOT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            r_state;
  logic [7:0]        r_opcode;
  logic [STEP_W-1:0] r_step;
  logic              r_cb_mode;
  logic [15:0]       r_retired;
  logic              r_ucode_err;

  logic [1:0] w_adv;
  logic       w_run;
  logic       w_stall;
  logic       w_next_req;
  logic       w_end_req;
  logic       w_ovf;
  logic       w_end;
  logic       w_adv_step;

  always_comb begin
    w_adv      = ucode_data[34:33];
    w_run      = (r_state == ST_RUN);
    // Either bus strobe low means this step owns a bus cycle that must complete.
    w_stall    = w_run && (!ucode_data[35] || !ucode_data[5]) && !mem_ready;
    w_next_req = (w_adv == 2'b00) || (w_adv == 2'b10 && cond_met) ||
                 (w_adv == 2'b11 && wake);
    w_end_req  = (w_adv == 2'b01) || (w_adv == 2'b10 && !cond_met);
    w_ovf      = w_run && !w_stall && w_next_req && (&r_step);
    w_end      = w_run && !w_stall && (w_end_req || w_ovf);
    w_adv_step = w_run && !w_stall && w_next_req && !(&r_step);
  end

  assign ucode_addr      = {r_cb_mode, r_opcode, r_step};
  assign control_signals = w_run ? ucode_data : IDLE_WORD;
  assign inst_done       = w_end && !reset;
  assign cb_mode         = r_cb_mode;
  assign retired         = r_retired;
  assign ucode_err       = r_ucode_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_BOOT;
      r_opcode    <= 8'h00;
      r_step      <= '0;
      r_cb_mode   <= 1'b0;
      r_retired   <= 16'h0000;
      r_ucode_err <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state   <= ST_RUN;
          r_opcode  <= 8'h00;
          r_step    <= '0;
          r_cb_mode <= 1'b0;
        end
        default: begin
          if (w_end) begin
            r_opcode  <= inst_byte;
            r_step    <= '0;
            r_retired <= r_retired + 16'd1;
            // The page toggle belongs to a genuine END; an overflow-forced end drops to page 0.
            r_cb_mode <= (!w_ovf && ucode_data[48]) ? ~r_cb_mode : 1'b0;
            if (w_ovf) r_ucode_err <= 1'b1;
          end else if (w_adv_step) begin
            r_step <= r_step + STEP_W'(1);
          end
        end
      endcase
    end
  end

endmodule
